baud_tick_gen: RTL
==================

Name: baud_tick_gen

Overview:
- Parametrised successor to the fixed divide-by-652 sample-clock generator.
- Produces single-cycle oversample ticks from `clk` using a runtime-loadable divisor.
- Adds an oversample phase counter that emits per-bit and mid-bit ticks.
- Adds enable and phase-resync inputs, so the UART receiver can align sampling to a detected start-bit edge.

Parameters:
- DIV_W, 16: width of the divisor and prescale counter.
- DEFAULT_DIV, 651: divisor loaded at reset. Tick period is DEFAULT_DIV+1 clk cycles (50 MHz, 9600 baud, 8x oversample).
- OSR, 8: oversample ratio, i.e. sample ticks per bit. Must be >= 2.
- OSR_W, $clog2(OSR): width of the oversample phase counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable
- div  in  DIV_W  new divisor value
- div_load  in  1  load `div` into the divisor register and restart phase
- sync_clr  in  1  restart prescale and oversample phase (start-bit resync)
- sample_tick  out  1  one-cycle pulse, once per divisor period
- bit_tick  out  1  one-cycle pulse on the last sample of each bit
- mid_tick  out  1  one-cycle pulse on sample OSR/2-1 of each bit (mid-bit)
- osr_phase  out  OSR_W  current oversample index, 0..OSR-1

Behaviour:
- Internal registers: `div_q` (DIV_W), `cnt` (DIV_W), `osr_cnt` (OSR_W). `osr_phase` = `osr_cnt`.
- Reset (`rst` high at a `clk` edge):
  - `div_q` <= DEFAULT_DIV; `cnt` <= 0; `osr_cnt` <= 0.
  - `sample_tick`, `bit_tick`, `mid_tick` <= 0.
  - `rst` overrides every other input.
- Priority per cycle: `rst` > `div_load` > `sync_clr` > `en`.
- `div_load`:
  - `div_q` <= `div`; `cnt` <= 0; `osr_cnt` <= 0; all ticks <= 0.
  - Applies regardless of `en`.
- `sync_clr`: `cnt` <= 0; `osr_cnt` <= 0; all ticks <= 0. Applies regardless of `en`.
- `en` low (no load, no clear): all counters hold; all ticks <= 0.
- `en` high, normal counting:
  - wrap = (`cnt` == `div_q`).
  - If wrap: `cnt` <= 0, else `cnt` <= `cnt`+1.
  - `sample_tick` <= wrap.
  - On wrap, `osr_cnt` advances modulo OSR (OSR-1 -> 0). Otherwise it holds.
  - `bit_tick` <= wrap && (`osr_cnt` == OSR-1).
  - `mid_tick` <= wrap && (`osr_cnt` == OSR/2-1).
- Latency: every tick is registered and asserts the cycle after the wrap condition. All outputs come directly from flops.
- Divisor 0: wrap on every enabled cycle, so `sample_tick` stays high continuously while `en` is high.
- Divisor 2^DIV_W-1: `cnt` reaches all-ones, then returns to 0. No overflow beyond that.
- Ticks are never high for more than one cycle, except with divisor 0.
- A new `div` takes effect only through `div_load`. Changing `div` without `div_load` has no effect.
- `sync_clr` held high for several cycles: counters stay at 0. Counting resumes on the first cycle with `sync_clr` low and `en` high.
- OSR not a power of two: `osr_cnt` still wraps at OSR-1. Unused codes are unreachable.

Decomposition:
- Shared package `uart_pkg`:
  - constants CLK_HZ=50_000_000, BAUD=9600, OSR=8;
  - DEFAULT_DIV = CLK_HZ/(BAUD*OSR) - 1 = 650 (exact). The codebase uses 651; keep 651 as the parameter default for compatibility;
  - DIV_W.
- One sub-module is natural: `mod_counter` (width, load, clear, inc, terminal-count output).
  - Instantiated once for the prescaler (`inc` = `en`, limit `div_q`).
  - Instantiated once for the oversample counter (`inc` = wrap, limit OSR-1).

Test Plan:
- Reset, then `en`=1 held with defaults (cycle 0 = first cycle after `rst` low):
  - `sample_tick` first high at cycle 652, then every 652 cycles;
  - `mid_tick` first at 2608;
  - `bit_tick` first at 5216, then every 5216.
- `div_load` with `div`=3 mid-count -> `cnt`/`osr_phase` restart at 0; `sample_tick` every 4 cycles; `bit_tick` every 32.
- `en` toggled low for 10 cycles just before a wrap -> tick delayed by exactly 10 cycles; no tick while `en` low; `osr_phase` frozen.
- `sync_clr` pulsed when `osr_phase`=5 -> `osr_phase`=0 next cycle; next `mid_tick` exactly 4*(`div_q`+1) cycles later.
- `div_load` and `sync_clr` asserted together with `div`=0 -> `div_q`=0; `sample_tick` high every enabled cycle afterwards; `bit_tick` every 8 cycles.
- `rst` asserted mid-count after `div_load` 3 -> `div_q` back to 651, all ticks 0 next cycle, `osr_phase`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART timing constants: system clock, baud rate, oversample ratio
// and the sample-clock divisor.
package uart_pkg;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned BAUD        = 9600;
    localparam int unsigned OSR         = 8;
    localparam int unsigned DIV_W       = 16;
    // The exact divisor is 650; existing users were built around 651.
    localparam int unsigned EXACT_DIV   = CLK_HZ / (BAUD * OSR) - 1;
    localparam int unsigned DEFAULT_DIV = 651;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter: counts 0..limit when inc is high, then wraps to 0.
// tc_c flags that the current count equals the limit.
module mod_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc_c
);

    assign tc_c = (count == limit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= tc_c ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: prescaler with runtime-loadable divisor feeding
// an oversample phase counter that marks mid-bit and end-of-bit samples.
module baud_tick_gen #(
    parameter int unsigned DIV_W       = uart_pkg::DIV_W,
    parameter int unsigned DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
    parameter int unsigned OSR         = uart_pkg::OSR,
    parameter int unsigned OSR_W       = $clog2(OSR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             div_load,
    input  logic             sync_clr,
    output logic             sample_tick,
    output logic             bit_tick,
    output logic             mid_tick,
    output logic [OSR_W-1:0] osr_phase
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic [OSR_W-1:0] osr_cnt;
    logic             restart_c;
    logic             pre_tc_c;
    logic             osr_tc_c;
    logic             wrap_c;
    logic             mid_c;

    // A divisor load also restarts the phase, exactly like a resync.
    assign restart_c = div_load || sync_clr;
    assign wrap_c    = en && pre_tc_c;
    assign mid_c     = (osr_cnt == OSR_W'(OSR / 2 - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_W'(DEFAULT_DIV);
        end else if (div_load) begin
            div_q <= div;
        end
    end

    mod_counter #(
        .W (DIV_W)
    ) u_prescale (
        .clk   (clk),
        .rst   (rst),
        .clear (restart_c),
        .inc   (en),
        .limit (div_q),
        .count (cnt),
        .tc_c  (pre_tc_c)
    );

    mod_counter #(
        .W (OSR_W)
    ) u_oversample (
        .clk   (clk),
        .rst   (rst),
        .clear (restart_c),
        .inc   (wrap_c),
        .limit (OSR_W'(OSR - 1)),
        .count (osr_cnt),
        .tc_c  (osr_tc_c)
    );

    // Ticks are registered one cycle after the wrap they report.
    always_ff @(posedge clk) begin
        if (rst || restart_c || !en) begin
            sample_tick <= 1'b0;
            bit_tick    <= 1'b0;
            mid_tick    <= 1'b0;
        end else begin
            sample_tick <= wrap_c;
            bit_tick    <= wrap_c && osr_tc_c;
            mid_tick    <= wrap_c && mid_c;
        end
    end

    assign osr_phase = osr_cnt;

endmodule
